hazard_unit: RTL and testbench

- Pipeline control block beside the forwarding unit.
- Consumes the same register-index and forwarding-type information, plus memory handshakes and redirect events.
- Produces per-stage stall/flush enables for the IF/ID, ID/EX, EX/MEM and MEM/WB registers, and a redirect enable for the PC.
- Resolves hazards that forwarding cannot, using a small FSM for memory waits and trap drain, and keeps a saturating stall-cycle counter for performance monitoring.

---
 rtl/forwarding_unit_pkg.sv | 11 +
 rtl/hazard_unit_pkg.sv | 16 +
 rtl/hazard_unit_if.sv | 51 +++++
 rtl/hazard_unit_saturating_counter.sv | 19 +
 rtl/hazard_unit.sv | 172 +++++++++++++++++
 tb/tb_hazard_unit.sv | 214 +++++++++++++++++++++
 6 files changed

// File: rtl/forwarding_unit_pkg.sv
// Forwarding classes shared between the forwarding unit and the hazard unit.
package forwarding_unit_pkg;

  // Type1: operands needed in EX; Type2: operands needed in ID (decode-stage branch compare).
  typedef enum logic [1:0] {
    NoType = 2'd0,
    Type1  = 2'd1,
    Type2  = 2'd2
  } forwarding_type_t;

endpackage

// File: rtl/hazard_unit_pkg.sv
// Shared types and helpers for the pipeline hazard unit.
package hazard_unit_pkg;

  typedef enum logic [1:0] {
    Run       = 2'd0,
    MemWait   = 2'd1,
    TrapFlush = 2'd2
  } hazard_state_t;

  localparam int TRAP_CNT_W = 4;

  function automatic logic reg_match(input logic [4:0] rs, input logic [4:0] rd, input logic we);
    return (rs == rd) && (rd != 5'd0) && we;
  endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// Pipeline-side signal bundle for the hazard unit: register indices, handshakes, stage controls.
interface hazard_unit_if #(
  parameter int COUNTER_WIDTH = 32
);
  import forwarding_unit_pkg::*;

  forwarding_type_t         forwarding_type_id;
  logic [4:0]               rs1_id;
  logic [4:0]               rs2_id;
  logic [4:0]               rd_ex;
  logic [4:0]               rd_mem;
  logic                     reg_we_ex;
  logic                     mem_rd_en_ex;
  logic                     mem_rd_en_mem;
  logic                     zicsr_ex;
  logic                     mem_access_mem;
  logic                     dmem_ack;
  logic                     imem_ack;
  logic                     branch_taken_ex;
  logic                     trap_taken;

  logic                     stall_if;
  logic                     stall_id;
  logic                     stall_ex;
  logic                     stall_mem;
  logic                     flush_id;
  logic                     flush_ex;
  logic                     flush_mem;
  logic                     flush_wb;
  logic                     redirect_en;
  logic [COUNTER_WIDTH-1:0] stall_cycles;

  modport slave (
    input  forwarding_type_id, rs1_id, rs2_id, rd_ex, rd_mem,
           reg_we_ex, mem_rd_en_ex, mem_rd_en_mem, zicsr_ex,
           mem_access_mem, dmem_ack, imem_ack, branch_taken_ex, trap_taken,
    output stall_if, stall_id, stall_ex, stall_mem,
           flush_id, flush_ex, flush_mem, flush_wb,
           redirect_en, stall_cycles
  );

  modport master (
    output forwarding_type_id, rs1_id, rs2_id, rd_ex, rd_mem,
           reg_we_ex, mem_rd_en_ex, mem_rd_en_mem, zicsr_ex,
           mem_access_mem, dmem_ack, imem_ack, branch_taken_ex, trap_taken,
    input  stall_if, stall_id, stall_ex, stall_mem,
           flush_id, flush_ex, flush_mem, flush_wb,
           redirect_en, stall_cycles
  );

endinterface

// File: rtl/hazard_unit_saturating_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module saturating_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (enable && (count != {WIDTH{1'b1}})) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: per-stage stall/flush, PC redirect, and a stall-cycle monitor.
//   state     | meaning
//   Run       | normal issue; resolve trap, memory wait, branch, data and fetch hazards
//   MemWait   | data access outstanding; freeze IF..MEM, bubble into WB
//   TrapFlush | drain after trap/mret; every stage flushed until the down-counter expires
module hazard_unit
  import hazard_unit_pkg::*;
  import forwarding_unit_pkg::*;
#(
  parameter int TRAP_FLUSH_CYCLES = 2,
  parameter int COUNTER_WIDTH     = 32
) (
  input  logic         clock,
  input  logic         reset,
  hazard_unit_if.slave hz
);

  localparam logic [TRAP_CNT_W-1:0] TRAP_LOAD = TRAP_CNT_W'(TRAP_FLUSH_CYCLES - 1);

  hazard_state_t         state;
  hazard_state_t         state_next;
  logic [TRAP_CNT_W-1:0] trap_cnt;
  logic [TRAP_CNT_W-1:0] trap_cnt_next;

  logic rs1_ex_match;
  logic rs2_ex_match;
  logic rs1_mem_match;
  logic rs2_mem_match;
  logic load_use;
  logic branch_dep;
  logic resolve_run;

  logic stall_if;
  logic stall_id;
  logic stall_ex;
  logic stall_mem;
  logic flush_id;
  logic flush_ex;
  logic flush_mem;
  logic flush_wb;
  logic redirect_en;

  assign rs1_ex_match  = reg_match(hz.rs1_id, hz.rd_ex, hz.reg_we_ex);
  assign rs2_ex_match  = reg_match(hz.rs2_id, hz.rd_ex, hz.reg_we_ex);
  assign rs1_mem_match = reg_match(hz.rs1_id, hz.rd_mem, hz.mem_rd_en_mem);
  assign rs2_mem_match = reg_match(hz.rs2_id, hz.rd_mem, hz.mem_rd_en_mem);

  assign load_use = hz.mem_rd_en_ex && (rs1_ex_match || rs2_ex_match)
                    && (hz.forwarding_type_id != NoType);

  // A Zicsr result on rs1 is already forwardable to decode, so only that pairing is exempt.
  assign branch_dep = (hz.forwarding_type_id == Type2)
                      && ((((rs1_ex_match || rs2_ex_match) && !(hz.zicsr_ex && rs1_ex_match)))
                          || rs1_mem_match || rs2_mem_match);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= Run;
      trap_cnt <= '0;
    end else begin
      state    <= state_next;
      trap_cnt <= trap_cnt_next;
    end
  end

  always_comb begin
    state_next    = state;
    trap_cnt_next = trap_cnt;
    resolve_run   = 1'b0;
    stall_if      = 1'b0;
    stall_id      = 1'b0;
    stall_ex      = 1'b0;
    stall_mem     = 1'b0;
    flush_id      = 1'b0;
    flush_ex      = 1'b0;
    flush_mem     = 1'b0;
    flush_wb      = 1'b0;
    redirect_en   = 1'b0;

    if (reset) begin
      flush_id  = 1'b1;
      flush_ex  = 1'b1;
      flush_mem = 1'b1;
      flush_wb  = 1'b1;
    end else begin
      case (state)
        Run: begin
          if (hz.trap_taken) begin
            flush_id  = 1'b1;
            flush_ex  = 1'b1;
            flush_mem = 1'b1;
            flush_wb  = 1'b1;
            if (TRAP_FLUSH_CYCLES > 1) begin
              state_next    = TrapFlush;
              trap_cnt_next = TRAP_LOAD;
            end
          end else if (hz.mem_access_mem && !hz.dmem_ack) begin
            stall_if   = 1'b1;
            stall_id   = 1'b1;
            stall_ex   = 1'b1;
            stall_mem  = 1'b1;
            flush_wb   = 1'b1;
            state_next = MemWait;
          end else begin
            resolve_run = 1'b1;
          end
        end
        MemWait: begin
          if (!hz.dmem_ack) begin
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            stall_ex  = 1'b1;
            stall_mem = 1'b1;
            flush_wb  = 1'b1;
          end else begin
            resolve_run = 1'b1;
            state_next  = Run;
          end
        end
        TrapFlush: begin
          flush_id      = 1'b1;
          flush_ex      = 1'b1;
          flush_mem     = 1'b1;
          flush_wb      = 1'b1;
          trap_cnt_next = trap_cnt - TRAP_CNT_W'(1);
          if (trap_cnt <= TRAP_CNT_W'(1)) begin
            state_next = Run;
          end
        end
        default: begin
          state_next    = Run;
          trap_cnt_next = '0;
        end
      endcase

      if (resolve_run) begin
        if (hz.branch_taken_ex) begin
          redirect_en = 1'b1;
          flush_id    = 1'b1;
          flush_ex    = 1'b1;
        end else if (load_use || branch_dep) begin
          stall_if = 1'b1;
          stall_id = 1'b1;
          flush_ex = 1'b1;
        end else if (!hz.imem_ack) begin
          stall_if = 1'b1;
          flush_id = 1'b1;
        end
      end
    end
  end

  assign hz.stall_if    = stall_if;
  assign hz.stall_id    = stall_id;
  assign hz.stall_ex    = stall_ex;
  assign hz.stall_mem   = stall_mem;
  assign hz.flush_id    = flush_id;
  assign hz.flush_ex    = flush_ex;
  assign hz.flush_mem   = flush_mem;
  assign hz.flush_wb    = flush_wb;
  assign hz.redirect_en = redirect_en;

  saturating_counter #(
    .WIDTH(COUNTER_WIDTH)
  ) u_stall_counter (
    .clock  (clock),
    .reset  (reset),
    .enable (stall_if),
    .count  (hz.stall_cycles)
  );

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: drives on the falling edge, checks 1 ns later.
module tb_hazard_unit;
  import forwarding_unit_pkg::*;

  localparam int CW = 4;

  // {stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, flush_mem, flush_wb, redirect_en}
  localparam logic [8:0] O_NONE  = 9'b0000_0000_0;
  localparam logic [8:0] O_STALL = 9'b1100_0100_0;
  localparam logic [8:0] O_MEMW  = 9'b1111_0001_0;
  localparam logic [8:0] O_BRAN  = 9'b0000_1100_1;
  localparam logic [8:0] O_FLUSH = 9'b0000_1111_0;
  localparam logic [8:0] O_IMEM  = 9'b1000_1000_0;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  hazard_unit_if #(.COUNTER_WIDTH(CW)) hz ();

  hazard_unit #(
    .TRAP_FLUSH_CYCLES(2),
    .COUNTER_WIDTH    (CW)
  ) dut (
    .clock (clock),
    .reset (reset),
    .hz    (hz)
  );

  logic [8:0] outs;
  assign outs = {hz.stall_if, hz.stall_id, hz.stall_ex, hz.stall_mem,
                 hz.flush_id, hz.flush_ex, hz.flush_mem, hz.flush_wb, hz.redirect_en};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    hz.forwarding_type_id = NoType;
    hz.rs1_id          = 5'd0;
    hz.rs2_id          = 5'd0;
    hz.rd_ex           = 5'd0;
    hz.rd_mem          = 5'd0;
    hz.reg_we_ex       = 1'b0;
    hz.mem_rd_en_ex    = 1'b0;
    hz.mem_rd_en_mem   = 1'b0;
    hz.zicsr_ex        = 1'b0;
    hz.mem_access_mem  = 1'b0;
    hz.dmem_ack        = 1'b1;
    hz.imem_ack        = 1'b1;
    hz.branch_taken_ex = 1'b0;
    hz.trap_taken      = 1'b0;
  endtask

  task automatic load_use_inputs(input logic [4:0] rd);
    hz.forwarding_type_id = Type1;
    hz.mem_rd_en_ex = 1'b1;
    hz.reg_we_ex    = 1'b1;
    hz.rd_ex        = rd;
    hz.rs1_id       = 5'd5;
  endtask

  task automatic settle_check(input string tag, input logic [8:0] exp);
    #1;
    check_eq(tag, 32'(outs), 32'(exp));
  endtask

  task automatic sc_check(input string tag, input int exp);
    check_eq(tag, 32'(hz.stall_cycles), 32'(exp));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    idle();
    settle_check("reset_outs", O_FLUSH);
    sc_check("reset_sc", 0);

    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    settle_check("idle", O_NONE);

    // load-use
    @(negedge clock);
    load_use_inputs(5'd5);
    settle_check("load_use", O_STALL);
    @(negedge clock);
    sc_check("load_use_sc", 1);
    idle();
    settle_check("load_use_one_cycle", O_NONE);
    @(negedge clock);
    load_use_inputs(5'd0);
    settle_check("load_use_x0", O_NONE);
    @(negedge clock);
    load_use_inputs(5'd5);
    hz.forwarding_type_id = NoType;
    settle_check("load_use_notype", O_NONE);
    @(negedge clock);
    sc_check("sc_after_no_stall", 1);

    // decode-stage branch dependency
    idle();
    hz.forwarding_type_id = Type2;
    hz.rd_ex     = 5'd7;
    hz.rs1_id    = 5'd7;
    hz.reg_we_ex = 1'b1;
    settle_check("bdep_rs1", O_STALL);
    @(negedge clock);
    hz.zicsr_ex = 1'b1;
    settle_check("bdep_rs1_zicsr", O_NONE);
    @(negedge clock);
    hz.rs1_id = 5'd3;
    hz.rs2_id = 5'd7;
    settle_check("bdep_rs2_zicsr", O_STALL);
    @(negedge clock);
    idle();
    hz.forwarding_type_id = Type2;
    hz.rs1_id        = 5'd9;
    hz.rd_mem        = 5'd9;
    hz.mem_rd_en_mem = 1'b1;
    settle_check("bdep_mem_load", O_STALL);
    @(negedge clock);
    hz.forwarding_type_id = Type1;
    settle_check("type1_mem_load", O_NONE);
    @(negedge clock);
    sc_check("sc_after_bdep", 4);

    // memory wait with a pending branch
    idle();
    hz.mem_access_mem  = 1'b1;
    hz.dmem_ack        = 1'b0;
    hz.branch_taken_ex = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle_check($sformatf("memwait_%0d", i), O_MEMW);
      @(negedge clock);
    end
    sc_check("sc_after_memwait", 7);
    hz.dmem_ack = 1'b1;
    settle_check("memwait_ack_redirect", O_BRAN);
    @(negedge clock);
    idle();
    hz.dmem_ack = 1'b0;
    settle_check("memwait_back_to_run", O_NONE);

    // trap with a concurrent load-use
    @(negedge clock);
    idle();
    load_use_inputs(5'd5);
    hz.trap_taken = 1'b1;
    settle_check("trap_cycle", O_FLUSH);
    @(negedge clock);
    hz.trap_taken = 1'b0;
    settle_check("trap_drain", O_FLUSH);
    @(negedge clock);
    settle_check("trap_done", O_STALL);
    @(negedge clock);
    sc_check("sc_after_trap", 8);

    // trap during a memory wait is ignored
    idle();
    hz.mem_access_mem = 1'b1;
    hz.dmem_ack       = 1'b0;
    settle_check("memwait_pre_trap", O_MEMW);
    @(negedge clock);
    hz.trap_taken = 1'b1;
    settle_check("memwait_trap_ignored", O_MEMW);
    @(negedge clock);
    idle();
    settle_check("memwait_trap_ack", O_NONE);
    @(negedge clock);
    settle_check("no_trap_drain", O_NONE);
    sc_check("sc_before_sat", 10);

    // saturation of the 4-bit counter
    hz.imem_ack = 1'b0;
    settle_check("imem_stall", O_IMEM);
    for (int i = 0; i < 4; i++) @(negedge clock);
    sc_check("sc_14", 14);
    for (int i = 0; i < 16; i++) @(negedge clock);
    sc_check("sc_saturated", 15);

    // asynchronous reset in the middle of a memory wait
    idle();
    hz.mem_access_mem = 1'b1;
    hz.dmem_ack       = 1'b0;
    @(negedge clock);
    settle_check("memwait_before_reset", O_MEMW);
    reset = 1'b1;
    #1;
    check_eq("async_reset_outs", 32'(outs), 32'(O_FLUSH));
    sc_check("async_reset_sc", 0);
    #1;
    reset = 1'b0;
    hz.mem_access_mem = 1'b0;
    settle_check("run_after_reset", O_NONE);
    @(negedge clock);
    settle_check("run_after_reset_edge", O_NONE);
    sc_check("sc_after_reset", 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
